serial_out_arbiter: RTL and testbench
=====================================

Name: serial_out_arbiter

Overview:
- Shares one serial LED/segment shift chain (clock, data, clear, latch-enable) between NREQ parallel-word requesters.
- Arbitrates round-robin, captures the granted word, and shifts it out MSB-first with a divided shift clock.
- Pulses the latch enable after the last bit, then reports completion to the owning requester.
- Sits between the GPIO/display register blocks and the board's external shift-register pins.

Parameters:
DATA_BITS, 16, width of each requester word and number of bits shifted per transfer
NREQ, 2, number of requesters (>=2)
CLK_DIV, 2, clk cycles per sclk half-period and per latch pulse (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  level request per requester; held until gnt
data_in  input  NREQ*DATA_BITS  requester i word at [i*DATA_BITS +: DATA_BITS]
gnt  output  NREQ  one-cycle one-hot pulse; data_in of that requester captured this edge
done  output  NREQ  one-cycle one-hot pulse; latch for that requester's word completed
busy  output  1  high in any state except IDLE
sclk  output  1  shift clock to chain; receiver samples on rising edge
sdata  output  1  serial data, MSB first
sclrn  output  1  active-low chain clear
spen  output  1  latch/output-enable pulse to chain

Behaviour:
- Reset (async, rst_n=0):
  - state=CLR; gnt=0, done=0, sclk=0, spen=0, sclrn=0; shift reg=0, so sdata=0; busy=1.
  - RR pointer=NREQ-1, so requester 0 wins first.
- States: CLR, IDLE, SHIFT_LO, SHIFT_HI, LATCH. All outputs are registered or decoded from registered state.
- CLR:
  - sclrn=0 for CLK_DIV cycles after rst_n release, then IDLE.
- IDLE:
  - sclrn=1, sclk=0, spen=0.
  - If any req bit is set, pick the first set bit searching from pointer+1 modulo NREQ.
  - Same edge: shreg<=data_in[winner], gnt[winner]<=1, pointer<=winner, bitcnt<=DATA_BITS-1, divcnt<=0, state<=SHIFT_LO.
- SHIFT_LO:
  - sclk=0, sdata=shreg[MSB]; after CLK_DIV cycles go to SHIFT_HI.
- SHIFT_HI:
  - sclk=1, sdata stable; after CLK_DIV cycles:
    - if bitcnt==0, go to LATCH;
    - else shreg<<=1, bitcnt--, go to SHIFT_LO.
- LATCH:
  - sclk=0, spen=1 for CLK_DIV cycles.
  - On exit: done[pointer]<=1 for one cycle, state<=IDLE.
- Latency: gnt pulse to done pulse = 2*CLK_DIV*DATA_BITS + CLK_DIV cycles.
- Requests and data:
  - req arriving during a transfer is ignored until IDLE; requests are not queued beyond the req level.
  - data_in is sampled only on the gnt edge; changes afterwards have no effect.
  - A requester holding req after gnt is re-arbitrated in the next IDLE cycle.
  - With all requesters asserting, grants rotate strictly.
- Back-to-back: done and the next gnt occur on consecutive edges, one IDLE cycle apart.
- Reset mid-transfer: immediate abort; no done; chain is cleared via CLR; pointer is reinitialised.
- Counter widths:
  - bitcnt is $clog2(DATA_BITS) bits.
  - divcnt is $clog2(CLK_DIV)+1 bits.
  - No wrap beyond terminal counts.

Decomposition:
- Shared package: state encoding enum (CLR, IDLE, SHIFT_LO, SHIFT_HI, LATCH) and a clog2 width helper constant function.
- One sub-module: rr_arbiter (NREQ req in, pointer in, one-hot winner + valid out, combinational).
- Shifter, divider and FSM stay in the top module.

Test Plan:
- Reset release, no req: sclrn low exactly 2 cycles, then high; busy falls; sclk/sdata/spen/gnt/done stay 0.
- Single transfer: req[0] with data 16'hA5C3.
  - gnt[0] is a single pulse.
  - 16 sclk rising edges sample 1010_0101_1100_0011.
  - spen is high 2 cycles after the last sclk fall.
  - done[0] comes 66 cycles after gnt[0].
- Contention: req=2'b11 held continuously → grants 0,1,0,1, each separated by a full transfer; data words 16'h0001/16'h8000 appear correctly on sdata.
- Late request: req[1] rises at bit 5 of the req[0] transfer.
  - No gnt[1] until after done[0]; gnt[1] follows on the next edge.
  - Changing data_in[0] mid-transfer does not alter the shifted bits.
- Reset abort: rst_n low during SHIFT_HI of bit 7.
  - Outputs go to reset values asynchronously; no done.
  - After release: CLR for 2 cycles, then a fresh transfer from requester 0 shifts its full word.
- CLK_DIV=1, DATA_BITS=8, data 8'h3C: sclk period is 2 cycles; bits are 00111100; spen is 1 cycle; gnt-to-done is 17 cycles.

Source files
------------

// File: rtl/serial_out_arbiter_pkg.sv
// rtl/serial_out_arbiter_pkg.sv - shared state encoding and width helper for the serial chain arbiter
package serial_out_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_CLR      = 3'd0,
        ST_IDLE     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4
    } state_t;

    // Width of an index into n items; never below one bit so n=1 still yields a legal vector.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_out_arbiter_rr.sv
// rtl/serial_out_arbiter_rr.sv - combinational round-robin pick starting after the last winner
module rr_arbiter
    import serial_out_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0]          req,
    input  logic [clog2w(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]          grant,
    output logic                     valid
);

    localparam int PW = clog2w(NREQ);

    logic [PW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = PW'((int'(ptr) + i) % NREQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_out_arbiter.sv
// rtl/serial_out_arbiter.sv - shares one serial shift chain between NREQ word requesters
module serial_out_arbiter
    import serial_out_arbiter_pkg::*;
#(
    parameter int DATA_BITS = 16,
    parameter int NREQ      = 2,
    parameter int CLK_DIV   = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DATA_BITS-1:0] data_in,
    output logic [NREQ-1:0]           gnt,
    output logic [NREQ-1:0]           done,
    output logic                      busy,
    output logic                      sclk,
    output logic                      sdata,
    output logic                      sclrn,
    output logic                      spen
);

    localparam int PW = clog2w(NREQ);
    localparam int BW = clog2w(DATA_BITS);
    localparam int DW = $clog2(CLK_DIV) + 1;

    state_t               state;
    logic [PW-1:0]        ptr;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bitcnt;
    logic [DW-1:0]        divcnt;
    logic [NREQ-1:0]      win_oh;
    logic                 win_valid;
    logic [PW-1:0]        win_idx;
    logic [DATA_BITS-1:0] win_word;
    logic                 div_end;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (req),
        .ptr   (ptr),
        .grant (win_oh),
        .valid (win_valid)
    );

    always_comb begin
        win_idx  = '0;
        win_word = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = PW'(i);
                win_word = data_in[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    assign div_end = (divcnt == DW'(CLK_DIV - 1));

    // Chain pins decode straight from registered state so they never glitch.
    assign sclk  = (state == ST_SHIFT_HI);
    assign spen  = (state == ST_LATCH);
    assign sclrn = (state != ST_CLR);
    assign busy  = (state != ST_IDLE);
    assign sdata = shreg[DATA_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_CLR;
            ptr    <= PW'(NREQ - 1);
            shreg  <= '0;
            bitcnt <= '0;
            divcnt <= '0;
            gnt    <= '0;
            done   <= '0;
        end else begin
            gnt  <= '0;
            done <= '0;
            case (state)
                ST_CLR: begin
                    if (div_end) begin
                        divcnt <= '0;
                        state  <= ST_IDLE;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (win_valid) begin
                        shreg  <= win_word;
                        gnt    <= win_oh;
                        ptr    <= win_idx;
                        bitcnt <= BW'(DATA_BITS - 1);
                        divcnt <= '0;
                        state  <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (div_end) begin
                        divcnt <= '0;
                        state  <= ST_SHIFT_HI;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    if (div_end) begin
                        divcnt <= '0;
                        if (bitcnt == '0) begin
                            state <= ST_LATCH;
                        end else begin
                            shreg  <= shreg << 1;
                            bitcnt <= bitcnt - 1'b1;
                            state  <= ST_SHIFT_LO;
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                ST_LATCH: begin
                    if (div_end) begin
                        divcnt <= '0;
                        done   <= NREQ'(1) << ptr;
                        state  <= ST_IDLE;
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                default: state <= ST_CLR;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_out_arbiter.sv
// tb/tb_serial_out_arbiter.sv - randomized self-checking bench for serial_out_arbiter
module tb_serial_out_arbiter;

    localparam int LAT1 = 2 * 2 * 16 + 2;
    localparam int LAT2 = 2 * 1 * 8 + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  gnt, done;
    logic        busy, sclk, sdata, sclrn, spen;

    logic [1:0]  req2 = '0;
    logic [15:0] data2 = '0;
    logic [1:0]  gnt2, done2;
    logic        busy2, sclk2, sdata2, sclrn2, spen2;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done_cyc = -1000;
    int ptr_m = 1;

    int          x_tmo, x_gidx, x_nbits, x_lat, x_gcnt, x_scnt, x_sgap, x_bb, x_done_ok;
    logic [15:0] x_word;

    serial_out_arbiter #(.DATA_BITS(16), .NREQ(2), .CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
        .gnt(gnt), .done(done), .busy(busy), .sclk(sclk),
        .sdata(sdata), .sclrn(sclrn), .spen(spen)
    );

    serial_out_arbiter #(.DATA_BITS(8), .NREQ(2), .CLK_DIV(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .data_in(data2),
        .gnt(gnt2), .done(done2), .busy(busy2), .sclk(sclk2),
        .sdata(sdata2), .sclrn(sclrn2), .spen(spen2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rr_pick(input logic [1:0] r, input int p);
        for (int k = 1; k <= 2; k++) begin
            int j;
            j = (p + k) % 2;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    // Watches one whole transfer of the 16-bit instance from grant to done.
    task automatic xfer(input bit hold, input logic [1:0] late_mask, input bit scramble);
        int   n, gcyc, last_hi, first_sp;
        logic prev;
        bit   fin;
        x_tmo = 0; x_gidx = -1; x_word = '0; x_nbits = 0; x_lat = -1;
        x_gcnt = 0; x_scnt = 0; x_sgap = -1; x_bb = -1; x_done_ok = 0;
        last_hi = -1; first_sp = -1; prev = 1'b0; fin = 1'b0; n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 2'b00 && n < 200);
        if (gnt == 2'b00) begin
            x_tmo = 1;
            return;
        end
        gcyc = cyc;
        x_bb = gcyc - last_done_cyc;
        x_gcnt = 1;
        if (gnt == 2'b01) x_gidx = 0;
        if (gnt == 2'b10) x_gidx = 1;
        if (!hold && x_gidx >= 0) req[x_gidx] = 1'b0;
        n = 0;
        while (!fin && n < 400) begin
            @(negedge clk);
            n++;
            if (gnt != 2'b00) x_gcnt++;
            if (sclk && !prev) begin
                x_word = {x_word[14:0], sdata};
                x_nbits++;
                if (x_nbits == 5) begin
                    req = req | late_mask;
                    if (scramble && x_gidx >= 0) data_in[x_gidx*16 +: 16] = 16'($urandom);
                end
            end
            if (sclk) last_hi = cyc;
            if (spen) begin
                x_scnt++;
                if (first_sp < 0) first_sp = cyc;
            end
            prev = sclk;
            if (done != 2'b00) begin
                fin = 1'b1;
                x_lat = cyc - gcyc;
                x_done_ok = ((x_gidx >= 0) && (done == (2'b01 << x_gidx))) ? 1 : 0;
                last_done_cyc = cyc;
            end
        end
        if (!fin) x_tmo = 1;
        x_sgap = first_sp - last_hi;
    endtask

    task automatic test_reset();
        int n, bad;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sclrn, sclk, spen, sdata, gnt, done} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 100000000", {busy, sclrn, sclk, spen, sdata, gnt, done});
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sclrn && n < 10);
        checks++;
        if (n !== 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_clr_len: got cycles=%0d busy=%b want cycles=2 busy=0", n, busy);
        end
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({sclk, spen, sdata, gnt, done, busy} != 8'h00 || !sclrn) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_idle_quiet: got %0d bad cycles want 0", bad);
        end
    endtask

    task automatic test_div1();
        int          n, gcyc, lat, nb, sc, badgap, last_rise;
        logic [7:0]  w;
        logic [1:0]  g;
        logic        prev;
        bit          fin;
        req2 = 2'b01;
        data2[7:0] = 8'h3C;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt2 == 2'b00 && n < 100);
        g = gnt2;
        gcyc = cyc;
        req2 = 2'b00;
        w = '0; nb = 0; sc = 0; badgap = 0; last_rise = -1; prev = 1'b0; fin = 1'b0; lat = -1; n = 0;
        while (!fin && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk2 && !prev) begin
                w = {w[6:0], sdata2};
                nb++;
                if (last_rise >= 0 && cyc - last_rise != 2) badgap++;
                last_rise = cyc;
            end
            if (spen2) sc++;
            prev = sclk2;
            if (done2 != 2'b00) begin
                fin = 1'b1;
                lat = cyc - gcyc;
            end
        end
        checks++;
        if (g !== 2'b01) begin
            failures++;
            $display("FAIL div1_gnt: got %b want 01", g);
        end
        checks++;
        if (w !== 8'h3C || nb !== 8 || badgap !== 0) begin
            failures++;
            $display("FAIL div1_bits: got %b (%0d bits, %0d bad periods) want 00111100 (8 bits, 0)", w, nb, badgap);
        end
        checks++;
        if (lat !== LAT2 || sc !== 1) begin
            failures++;
            $display("FAIL div1_timing: got lat=%0d spen=%0d want lat=%0d spen=1", lat, sc, LAT2);
        end
    endtask

    task automatic test_single();
        data_in[15:0] = 16'hA5C3;
        req = 2'b01;
        xfer(1'b0, 2'b00, 1'b0);
        req = 2'b00;
        checks++;
        if (x_tmo !== 0 || x_gidx !== 0 || x_gcnt !== 1) begin
            failures++;
            $display("FAIL single_gnt: got tmo=%0d idx=%0d pulses=%0d want 0 0 1", x_tmo, x_gidx, x_gcnt);
        end
        checks++;
        if (x_word !== 16'hA5C3 || x_nbits !== 16) begin
            failures++;
            $display("FAIL single_bits: got %h (%0d bits) want a5c3 (16 bits)", x_word, x_nbits);
        end
        checks++;
        if (x_scnt !== 2 || x_sgap !== 1) begin
            failures++;
            $display("FAIL single_spen: got len=%0d gap=%0d want len=2 gap=1", x_scnt, x_sgap);
        end
        checks++;
        if (x_lat !== LAT1 || x_done_ok !== 1) begin
            failures++;
            $display("FAIL single_done: got lat=%0d ok=%0d want lat=%0d ok=1", x_lat, x_done_ok, LAT1);
        end
        ptr_m = 0;
    endtask

    task automatic test_late();
        logic [15:0] d0, d1;
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        data_in = {d1, d0};
        req = 2'b01;
        xfer(1'b0, 2'b10, 1'b1);
        checks++;
        if (x_tmo !== 0 || x_gidx !== 0 || x_gcnt !== 1 || x_word !== d0) begin
            failures++;
            $display("FAIL late_first: got idx=%0d pulses=%0d word=%h want 0 1 %h", x_gidx, x_gcnt, x_word, d0);
        end
        xfer(1'b0, 2'b00, 1'b0);
        req = 2'b00;
        checks++;
        if (x_tmo !== 0 || x_gidx !== 1 || x_bb !== 1 || x_word !== d1) begin
            failures++;
            $display("FAIL late_second: got idx=%0d gap=%0d word=%h want 1 1 %h", x_gidx, x_bb, x_word, d1);
        end
        ptr_m = 1;
    endtask

    task automatic test_back_to_back();
        int          exp;
        logic [15:0] ew;
        data_in = {16'h8000, 16'h0001};
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp = rr_pick(2'b11, ptr_m);
            ew = (exp == 1) ? 16'h8000 : 16'h0001;
            xfer(1'b1, 2'b00, 1'b0);
            if (k == 3) req = 2'b00;
            checks++;
            if (x_tmo !== 0 || x_gidx !== exp || x_word !== ew || x_done_ok !== 1) begin
                failures++;
                $display("FAIL rotate_%0d: got idx=%0d word=%h want %0d %h", k, x_gidx, x_word, exp, ew);
            end
            if (k > 0) begin
                checks++;
                if (x_bb !== 1) begin
                    failures++;
                    $display("FAIL rotate_gap_%0d: got %0d want 1", k, x_bb);
                end
            end
            ptr_m = exp;
        end
    endtask

    task automatic test_abort();
        int          n, nb, bad;
        logic        prev;
        logic [15:0] w;
        w = 16'($urandom) | 16'h8001;
        data_in[15:0] = w;
        req = 2'b01;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 2'b00 && n < 200);
        req = 2'b11;
        n = 0; nb = 0; prev = 1'b0;
        while (nb < 8 && n < 400) begin
            @(negedge clk);
            n++;
            if (sclk && !prev) nb++;
            prev = sclk;
        end
        checks++;
        if (nb !== 8 || sclk !== 1'b1) begin
            failures++;
            $display("FAIL abort_reach_bit7: got bits=%0d sclk=%b want 8 1", nb, sclk);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, sclrn, sclk, spen, sdata, gnt, done} !== 9'b1_0000_0000) begin
            failures++;
            $display("FAIL abort_async: got %b want 100000000", {busy, sclrn, sclk, spen, sdata, gnt, done});
        end
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (done != 2'b00) bad++;
        end
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (done != 2'b00) bad++;
        end while (!sclrn && n < 10);
        checks++;
        if (n !== 2 || bad !== 0) begin
            failures++;
            $display("FAIL abort_clr: got cycles=%0d stray_done=%0d want 2 0", n, bad);
        end
        xfer(1'b0, 2'b00, 1'b0);
        req = 2'b00;
        checks++;
        if (x_tmo !== 0 || x_gidx !== 0 || x_word !== w || x_nbits !== 16 || x_lat !== LAT1) begin
            failures++;
            $display("FAIL abort_fresh: got idx=%0d word=%h bits=%0d lat=%0d want 0 %h 16 %0d",
                     x_gidx, x_word, x_nbits, x_lat, w, LAT1);
        end
        ptr_m = 0;
    endtask

    task automatic test_random();
        int          exp;
        logic [1:0]  mask;
        logic [15:0] d0, d1, ew;
        for (int it = 0; it < 6; it++) begin
            mask = 2'($urandom_range(1, 3));
            d0 = 16'($urandom);
            d1 = 16'($urandom);
            data_in = {d1, d0};
            exp = rr_pick(mask, ptr_m);
            ew = (exp == 1) ? d1 : d0;
            req = mask;
            xfer(1'b0, 2'b00, 1'b0);
            req = 2'b00;
            checks++;
            if (x_tmo !== 0 || x_gidx !== exp || x_word !== ew || x_nbits !== 16) begin
                failures++;
                $display("FAIL random_%0d_data: got idx=%0d word=%h want %0d %h (mask %b)", it, x_gidx, x_word, exp, ew, mask);
            end
            checks++;
            if (x_lat !== LAT1 || x_gcnt !== 1 || x_scnt !== 2 || x_done_ok !== 1) begin
                failures++;
                $display("FAIL random_%0d_timing: got lat=%0d pulses=%0d spen=%0d ok=%0d want %0d 1 2 1",
                         it, x_lat, x_gcnt, x_scnt, x_done_ok, LAT1);
            end
            ptr_m = exp;
            repeat (2) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_div1();
        test_single();
        test_late();
        test_back_to_back();
        test_abort();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
